// File: rtl/wb_commit_ctrl.sv
// Writeback commit controller: registers the memory-stage bundle, commits RF/CSR writes or exception/ERTN,
// and runs a one-cycle flush that redirects fetch. Outputs are combinational on the WB register; flush_req is a state decode.
module wb_commit_ctrl #(
   parameter int PC_W      = 32,
   parameter int CSR_NUM_W = 14,
   parameter int EXC_W     = 6
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ms_to_ws_valid,
   output logic                 ws_allowin,
   input  logic [PC_W-1:0]      ms_pc,
   input  logic [EXC_W-1:0]     ms_exc,
   input  logic                 ms_is_ertn,
   input  logic [PC_W-1:0]      ms_vaddr,
   input  logic                 ms_csr_we,
   input  logic [CSR_NUM_W-1:0] ms_csr_num,
   input  logic [31:0]          ms_csr_mask,
   input  logic [31:0]          ms_csr_wdata,
   input  logic                 ms_rf_we,
   input  logic [4:0]           ms_rf_waddr,
   input  logic [31:0]          ms_rf_wdata,
   input  logic                 has_int,
   input  logic [PC_W-1:0]      csr_eentry_pc,
   input  logic [PC_W-1:0]      csr_eertn_pc,
   output logic [EXC_W-1:0]     exc,
   output logic                 ertn_flush,
   output logic [PC_W-1:0]      wb_pc,
   output logic [PC_W-1:0]      wb_fault_vaddr,
   output logic                 csr_we,
   output logic [CSR_NUM_W-1:0] csr_wr_num,
   output logic [31:0]          csr_wr_mask,
   output logic [31:0]          csr_wr_value,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 flush_req,
   output logic [PC_W-1:0]      flush_target
);

   localparam int B_INT  = 5;
   localparam int B_ADEF = 4;
   localparam int B_ALE  = 3;
   localparam int B_BRK  = 2;
   localparam int B_INE  = 1;
   localparam int B_SYS  = 0;

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t                 state;
   logic                   ws_valid;
   logic [EXC_W-1:0]       ws_exc;
   logic                   ws_is_ertn;
   logic                   ws_csr_we;
   logic                   ws_rf_we;
   logic [EXC_W-1:0]       exc_sel;
   logic                   commit;
   logic                   ex_commit;

   // The upstream INT flag is meaningless here; has_int from the CSR file decides interrupts.
   logic unused_ms_int;
   assign unused_ms_int = ms_exc[B_INT];

   assign ws_allowin = ~ws_valid | (state == S_RUN);
   assign commit     = ws_valid & (state == S_RUN);

   always_comb begin
      exc_sel = '0;
      if (has_int)             exc_sel[B_INT]  = 1'b1;
      else if (ws_exc[B_ADEF]) exc_sel[B_ADEF] = 1'b1;
      else if (ws_exc[B_INE])  exc_sel[B_INE]  = 1'b1;
      else if (ws_exc[B_SYS])  exc_sel[B_SYS]  = 1'b1;
      else if (ws_exc[B_BRK])  exc_sel[B_BRK]  = 1'b1;
      else if (ws_exc[B_ALE])  exc_sel[B_ALE]  = 1'b1;
   end

   assign exc        = commit ? exc_sel : '0;
   assign ex_commit  = |exc;
   assign ertn_flush = commit & ws_is_ertn & ~ex_commit;
   assign rf_we      = commit & ws_rf_we & ~ex_commit & ~ertn_flush;
   assign csr_we     = commit & ws_csr_we & ~ex_commit;
   assign flush_req  = (state == S_FLUSH);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_RUN;
         ws_valid       <= 1'b0;
         flush_target   <= '0;
         wb_pc          <= '0;
         ws_exc         <= '0;
         ws_is_ertn     <= 1'b0;
         wb_fault_vaddr <= '0;
         ws_csr_we      <= 1'b0;
         csr_wr_num     <= '0;
         csr_wr_mask    <= '0;
         csr_wr_value   <= '0;
         ws_rf_we       <= 1'b0;
         rf_waddr       <= '0;
         rf_wdata       <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (ex_commit || ertn_flush) begin
                  // Whatever the memory stage offers now is younger and gets squashed.
                  state        <= S_FLUSH;
                  ws_valid     <= 1'b0;
                  flush_target <= ex_commit ? csr_eentry_pc : csr_eertn_pc;
               end else begin
                  ws_valid <= ws_allowin & ms_to_ws_valid;
                  if (ws_allowin && ms_to_ws_valid) begin
                     wb_pc          <= ms_pc;
                     ws_exc         <= ms_exc;
                     ws_is_ertn     <= ms_is_ertn;
                     wb_fault_vaddr <= ms_vaddr;
                     ws_csr_we      <= ms_csr_we;
                     csr_wr_num     <= ms_csr_num;
                     csr_wr_mask    <= ms_csr_mask;
                     csr_wr_value   <= ms_csr_wdata;
                     ws_rf_we       <= ms_rf_we;
                     rf_waddr       <= ms_rf_waddr;
                     rf_wdata       <= ms_rf_wdata;
                  end
               end
            end
            default: begin
               state    <= S_RUN;
               ws_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Bench for wb_commit_ctrl: directed test-plan cases with literal expectations, then randomized traffic
// checked every cycle against an instruction-slot model.
module tb_wb_commit_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [5:0]  ms_exc;
   logic        ms_is_ertn;
   logic [31:0] ms_vaddr;
   logic        ms_csr_we;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_csr_mask;
   logic [31:0] ms_csr_wdata;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        has_int;
   logic [31:0] csr_eentry_pc;
   logic [31:0] csr_eertn_pc;
   logic [5:0]  exc;
   logic        ertn_flush;
   logic [31:0] wb_pc;
   logic [31:0] wb_fault_vaddr;
   logic        csr_we;
   logic [13:0] csr_wr_num;
   logic [31:0] csr_wr_mask;
   logic [31:0] csr_wr_value;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        flush_req;
   logic [31:0] flush_target;

   always #5 clk = ~clk;

   wb_commit_ctrl dut (
      .clk(clk), .resetn(resetn),
      .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
      .ms_pc(ms_pc), .ms_exc(ms_exc), .ms_is_ertn(ms_is_ertn), .ms_vaddr(ms_vaddr),
      .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_mask(ms_csr_mask),
      .ms_csr_wdata(ms_csr_wdata), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
      .ms_rf_wdata(ms_rf_wdata), .has_int(has_int), .csr_eentry_pc(csr_eentry_pc),
      .csr_eertn_pc(csr_eertn_pc), .exc(exc), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
      .wb_fault_vaddr(wb_fault_vaddr), .csr_we(csr_we), .csr_wr_num(csr_wr_num),
      .csr_wr_mask(csr_wr_mask), .csr_wr_value(csr_wr_value), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush_req(flush_req),
      .flush_target(flush_target)
   );

   typedef struct packed {
      logic        vld;
      logic [31:0] pc;
      logic [5:0]  ex;
      logic        ertn;
      logic [31:0] va;
      logic        cwe;
      logic [13:0] cnum;
      logic [31:0] cmask;
      logic [31:0] cdat;
      logic        rwe;
      logic [4:0]  wa;
      logic [31:0] wd;
   } ins_t;

   // Model: the instruction sitting in WB (if any), whether a flush cycle is due, and the redirect PC.
   ins_t        slot;
   bit          m_flush;
   logic [31:0] m_target;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Exception causes in falling priority, by bit position in {INT,ADEF,ALE,BRK,INE,SYS}.
   function automatic logic [5:0] model_exc();
      int order [5] = '{4, 1, 0, 2, 3};
      logic [5:0] r = '0;
      if (!slot.vld || m_flush) return r;
      if (has_int) begin
         r[5] = 1'b1;
         return r;
      end
      foreach (order[k]) if (slot.ex[order[k]]) begin
         r[order[k]] = 1'b1;
         return r;
      end
      return r;
   endfunction

   function automatic ins_t idle_ins();
      ins_t i = '0;
      return i;
   endfunction

   task automatic drive(input ins_t i);
      ms_to_ws_valid = i.vld;  ms_pc = i.pc;        ms_exc = i.ex;
      ms_is_ertn = i.ertn;     ms_vaddr = i.va;     ms_csr_we = i.cwe;
      ms_csr_num = i.cnum;     ms_csr_mask = i.cmask; ms_csr_wdata = i.cdat;
      ms_rf_we = i.rwe;        ms_rf_waddr = i.wa;  ms_rf_wdata = i.wd;
   endtask

   function automatic ins_t offered();
      ins_t i;
      i.vld = ms_to_ws_valid; i.pc = ms_pc; i.ex = ms_exc; i.ertn = ms_is_ertn;
      i.va = ms_vaddr; i.cwe = ms_csr_we; i.cnum = ms_csr_num; i.cmask = ms_csr_mask;
      i.cdat = ms_csr_wdata; i.rwe = ms_rf_we; i.wa = ms_rf_waddr; i.wd = ms_rf_wdata;
      return i;
   endfunction

   task automatic model_reset();
      slot = '0;
      m_flush = 1'b0;
      m_target = '0;
   endtask

   // Compare at negedge, well away from the active edge.
   task automatic cmp();
      logic [5:0] e_exc;
      logic       e_ertn;
      @(negedge clk);
      e_exc  = model_exc();
      e_ertn = slot.vld && slot.ertn && (e_exc == 0);
      chk("exc", exc, e_exc);
      chk("ertn_flush", ertn_flush, e_ertn);
      chk("rf_we", rf_we, slot.vld && slot.rwe && (e_exc == 0) && !e_ertn);
      chk("csr_we", csr_we, slot.vld && slot.cwe && (e_exc == 0));
      chk("flush_req", flush_req, m_flush);
      chk("flush_target", flush_target, m_target);
      chk("ws_allowin", ws_allowin, 1'b1);
      if (slot.vld) begin
         chk("wb_pc", wb_pc, slot.pc);
         chk("wb_fault_vaddr", wb_fault_vaddr, slot.va);
         chk("rf_waddr", rf_waddr, slot.wa);
         chk("rf_wdata", rf_wdata, slot.wd);
         chk("csr_wr_num", csr_wr_num, slot.cnum);
         chk("csr_wr_mask", csr_wr_mask, slot.cmask);
         chk("csr_wr_value", csr_wr_value, slot.cdat);
      end
   endtask

   // Advance the model across the next rising edge using the inputs currently driven.
   task automatic adv();
      logic [5:0] e_exc;
      e_exc = model_exc();
      if (m_flush) begin
         m_flush  = 1'b0;
         slot.vld = 1'b0;
      end else if (slot.vld && (e_exc != 0 || slot.ertn)) begin
         m_flush  = 1'b1;
         m_target = (e_exc != 0) ? csr_eentry_pc : csr_eertn_pc;
         slot.vld = 1'b0;
      end else begin
         slot = offered();
      end
      @(posedge clk);
      #1;
   endtask

   ins_t t;

   initial begin
      resetn = 1'b0;
      has_int = 1'b0;
      csr_eentry_pc = 32'h1c008000;
      csr_eertn_pc  = 32'h0;
      drive(idle_ins());
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst flush_req", flush_req, 1'b0);
      chk("rst ws_allowin", ws_allowin, 1'b1);
      chk("rst flush_target", flush_target, 32'h0);
      chk("rst rf_we", rf_we, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Plain ALU commit
      t = '0; t.vld = 1; t.pc = 32'h1c000010; t.rwe = 1; t.wa = 5; t.wd = 32'h1234;
      drive(t); cmp(); adv();
      drive(idle_ins()); cmp();
      chk("alu rf_we", rf_we, 1'b1);
      chk("alu rf_waddr", rf_waddr, 5'd5);
      chk("alu rf_wdata", rf_wdata, 32'h1234);
      chk("alu exc", exc, 6'b0);
      chk("alu flush_req", flush_req, 1'b0);
      adv();

      // SYSCALL, with younger valid instructions offered during commit and flush
      t = '0; t.vld = 1; t.pc = 32'h1c000040; t.ex = 6'b000001;
      drive(t); cmp(); adv();
      t = '0; t.vld = 1; t.pc = 32'h1c000044; t.rwe = 1; t.wa = 7; t.wd = 32'hdead;
      drive(t); cmp();
      chk("sys exc", exc, 6'b000001);
      chk("sys wb_pc", wb_pc, 32'h1c000040);
      chk("sys rf_we", rf_we, 1'b0);
      adv();
      cmp();
      chk("sys flush_req", flush_req, 1'b1);
      chk("sys flush_target", flush_target, 32'h1c008000);
      chk("sys young rf_we", rf_we, 1'b0);
      adv();
      drive(idle_ins()); cmp();
      chk("sys squashed rf_we", rf_we, 1'b0);
      chk("sys flush done", flush_req, 1'b0);
      adv();

      // Priority: ADEF beats ALE and BRK
      t = '0; t.vld = 1; t.pc = 32'h1c000080; t.ex = 6'b011100;
      drive(t); cmp(); adv();
      drive(idle_ins()); cmp();
      chk("prio exc", exc, 6'b010000);
      adv(); cmp(); adv();
      // ALE alone
      t = '0; t.vld = 1; t.pc = 32'h1c000090; t.ex = 6'b001000; t.va = 32'h3;
      drive(t); cmp(); adv();
      drive(idle_ins()); cmp();
      chk("ale exc", exc, 6'b001000);
      chk("ale vaddr", wb_fault_vaddr, 32'h3);
      adv(); cmp(); adv();

      // Interrupt overrides a CSR write
      csr_eentry_pc = 32'h1c00c000;
      t = '0; t.vld = 1; t.pc = 32'h1c0000a0; t.cwe = 1; t.cnum = 14'h6; t.cmask = '1; t.cdat = 32'h55;
      drive(t); cmp(); adv();
      drive(idle_ins()); has_int = 1'b1; cmp();
      chk("int exc", exc, 6'b100000);
      chk("int csr_we", csr_we, 1'b0);
      adv();
      has_int = 1'b0; cmp();
      chk("int flush_target", flush_target, 32'h1c00c000);
      adv();

      // ERTN, then async reset in the middle of its flush cycle
      csr_eertn_pc = 32'h1c000044;
      t = '0; t.vld = 1; t.pc = 32'h1c0000b0; t.ertn = 1;
      drive(t); cmp(); adv();
      drive(idle_ins()); cmp();
      chk("ertn ertn_flush", ertn_flush, 1'b1);
      chk("ertn exc", exc, 6'b0);
      adv();
      cmp();
      chk("ertn flush_req", flush_req, 1'b1);
      chk("ertn flush_target", flush_target, 32'h1c000044);
      chk("ertn pulse", ertn_flush, 1'b0);
      #1 resetn = 1'b0;
      #1;
      chk("arst flush_req", flush_req, 1'b0);
      chk("arst rf_we", rf_we, 1'b0);
      chk("arst csr_we", csr_we, 1'b0);
      chk("arst exc", exc, 6'b0);
      chk("arst ertn_flush", ertn_flush, 1'b0);
      chk("arst ws_allowin", ws_allowin, 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      cmp();
      chk("post-rst flush_req", flush_req, 1'b0);
      chk("post-rst ws_allowin", ws_allowin, 1'b1);
      adv();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         t.vld   = ($urandom_range(0, 9) < 7);
         t.pc    = $urandom;
         t.ex    = '0;
         for (int b = 0; b < 6; b++) t.ex[b] = ($urandom_range(0, 11) == 0);
         t.ertn  = ($urandom_range(0, 9) == 0);
         t.va    = $urandom;
         t.cwe   = $urandom_range(0, 1);
         t.cnum  = 14'($urandom);
         t.cmask = $urandom;
         t.cdat  = $urandom;
         t.rwe   = $urandom_range(0, 1);
         t.wa    = 5'($urandom);
         t.wd    = $urandom;
         drive(t);
         has_int       = ($urandom_range(0, 19) == 0);
         csr_eentry_pc = $urandom;
         csr_eertn_pc  = $urandom;
         cmp();
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
